// File: rtl/input_conditioner_pkg.sv
// Shared constants and types for the pushbutton/switch front end.
// Button indices, data width and press-FSM encoding used by the top and the bench.
package input_conditioner_pkg;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int DATA_W                  = 4;
   localparam int NUM_BTN                 = 2;
   localparam int BTN_SUBMIT              = 0;
   localparam int BTN_NEXT                = 1;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESSED = 1'b1
   } press_state_t;
endpackage

// File: rtl/input_conditioner_debounce_cell.sv
// Two-flop synchroniser followed by a stability counter; a new level is accepted
// only after DEBOUNCE_CYCLES consecutive synchronised samples that differ from the current one.
module debounce_cell #(
   parameter  int WIDTH           = 1,
   parameter  int DEBOUNCE_CYCLES = 500000,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] level
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s1_q, s2_q;
   logic [WIDTH-1:0] level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (s2_q != level_q) begin
         // >= keeps the counter from ever running past the accept point
         if (cnt_q >= CNT_LAST) begin
            level_d = s2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         level_q <= '0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= din;
         s2_q    <= s1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
endmodule

// File: rtl/input_conditioner.sv
// Debounced press detection for submit/next buttons plus switch snapshot on submit.
// Next-level wins when both presses are accepted on the same cycle.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_submit,
   input  logic              btn_next,
   input  logic [DATA_W-1:0] sw_data,
   output logic              submit,
   output logic              nextLevel,
   output logic [DATA_W-1:0] data
);
   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] press_ev;
   logic [DATA_W-1:0]  sw_level;

   press_state_t       state_q [NUM_BTN];
   press_state_t       state_d [NUM_BTN];
   logic               submit_q, submit_d;
   logic               next_q, next_d;
   logic [DATA_W-1:0]  data_q, data_d;

   assign btn_raw[BTN_SUBMIT] = btn_submit;
   assign btn_raw[BTN_NEXT]   = btn_next;

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         debounce_cell #(
            .WIDTH          (1),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_db (
            .clk  (clk),
            .reset(reset),
            .din  (btn_raw[gi]),
            .level(btn_level[gi])
         );
      end
   endgenerate

   debounce_cell #(
      .WIDTH          (DATA_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_sw (
      .clk  (clk),
      .reset(reset),
      .din  (sw_data),
      .level(sw_level)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_BTN; i++) begin
            state_q[i] <= ST_IDLE;
         end
         submit_q <= 1'b0;
         next_q   <= 1'b0;
         data_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            state_q[i] <= state_d[i];
         end
         submit_q <= submit_d;
         next_q   <= next_d;
         data_q   <= data_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            ST_IDLE:    if (btn_level[i])  state_d[i] = ST_PRESSED;
            ST_PRESSED: if (!btn_level[i]) state_d[i] = ST_IDLE;
         endcase
      end
   end

   // A dropped submit still moves its FSM to PRESSED, so it never fires late.
   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         press_ev[i] = (state_q[i] == ST_IDLE) && btn_level[i];
      end
      next_d   = press_ev[BTN_NEXT];
      submit_d = press_ev[BTN_SUBMIT] && !press_ev[BTN_NEXT];
      data_d   = submit_d ? sw_level : data_q;
   end

   assign submit    = submit_q;
   assign nextLevel = next_q;
   assign data      = data_q;
endmodule
